// File: rtl/bnn_scheduler.sv
// Inference sequencer for the BNN core. It launches the core on an armed, full
// image buffer, watches for completion with a bounded retry, and latches the class.
module bnn_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       img_buffer_full,
  input  logic       bnn_enable,
  input  logic       bnn_clear,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_result,
  output logic       img_consume,
  output logic [3:0] result_out,
  output logic       result_ready,
  output logic       timeout_err,
  output logic       busy,
  output logic [7:0] infer_count
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [1:0]  retry_cnt;
  logic        hit_done;
  logic        hit_retry;
  logic        err_clear;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    hit_done   = 1'b0;
    hit_retry  = 1'b0;
    err_clear  = 1'b0;
    case (state)
      IDLE:  if (bnn_enable && img_buffer_full) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        // Done takes priority over a timeout that expires in the same cycle.
        if (core_done) begin
          hit_done   = 1'b1;
          state_next = DONE;
        end else if (timer == TIMER_LAST) begin
          if (int'(retry_cnt) < MAX_RETRIES) begin
            hit_retry  = 1'b1;
            state_next = START;
          end else begin
            state_next = ERROR;
          end
        end
      end
      DONE:  if (bnn_clear) state_next = IDLE;
      ERROR: begin
        if (bnn_clear) begin
          err_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      core_start   <= 1'b0;
      img_consume  <= 1'b0;
      result_out   <= 4'd0;
      result_ready <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      infer_count  <= 8'd0;
      timer        <= 16'd0;
      retry_cnt    <= 2'd0;
    end else begin
      state       <= state_next;
      // Outputs are derived from the next state so they line up with it.
      core_start  <= (state_next == START);
      busy        <= (state_next == START) || (state_next == WAIT);
      timeout_err <= (state_next == ERROR);
      img_consume <= hit_done || err_clear;

      if (state == START)     timer <= 16'd0;
      else if (state == WAIT) timer <= timer + 16'd1;

      if (hit_done || err_clear) retry_cnt <= 2'd0;
      else if (hit_retry)        retry_cnt <= retry_cnt + 2'd1;

      if (hit_done) begin
        result_out   <= (core_result > 4'd9) ? 4'd9 : core_result;
        result_ready <= 1'b1;
        infer_count  <= infer_count + 8'd1;
      end else if (state == DONE && bnn_clear) begin
        result_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_scheduler.sv
// Directed bench for bnn_scheduler: dut_a uses the default timeout, dut_b a
// 16-cycle timeout; both share stimulus and are reset before each scenario.
module tb_bnn_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       img_buffer_full;
  logic       bnn_enable;
  logic       bnn_clear;
  logic       core_done;
  logic [3:0] core_result;

  logic       a_core_start, a_img_consume, a_result_ready, a_timeout_err, a_busy;
  logic [3:0] a_result_out;
  logic [7:0] a_infer_count;
  logic       b_core_start, b_img_consume, b_result_ready, b_timeout_err, b_busy;
  logic [3:0] b_result_out;
  logic [7:0] b_infer_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bnn_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .img_buffer_full(img_buffer_full),
    .bnn_enable(bnn_enable), .bnn_clear(bnn_clear), .core_start(a_core_start),
    .core_done(core_done), .core_result(core_result), .img_consume(a_img_consume),
    .result_out(a_result_out), .result_ready(a_result_ready),
    .timeout_err(a_timeout_err), .busy(a_busy), .infer_count(a_infer_count)
  );

  bnn_scheduler #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .img_buffer_full(img_buffer_full),
    .bnn_enable(bnn_enable), .bnn_clear(bnn_clear), .core_start(b_core_start),
    .core_done(core_done), .core_result(core_result), .img_consume(b_img_consume),
    .result_out(b_result_out), .result_ready(b_result_ready),
    .timeout_err(b_timeout_err), .busy(b_busy), .infer_count(b_infer_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    img_buffer_full = 1'b0;
    bnn_enable = 1'b0;
    bnn_clear = 1'b0;
    core_done = 1'b0;
    core_result = 4'd0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  // Request, then drop it once START is reached.
  task automatic launch();
    bnn_enable = 1'b1;
    img_buffer_full = 1'b1;
    tick();
    bnn_enable = 1'b0;
    img_buffer_full = 1'b0;
  endtask

  // Short inference on both DUTs: launch, one WAIT cycle, done, clear.
  task automatic quick_infer(input logic [3:0] res);
    launch();
    tick();
    core_done = 1'b1;
    core_result = res;
    tick();
    core_done = 1'b0;
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
  endtask

  initial begin
    int first_gap;
    int starts;
    int err_drops;
    int bad_evt;

    // Reset state
    do_reset();
    check("rst_core_start", a_core_start, 0);
    check("rst_result_out", a_result_out, 0);
    check("rst_result_ready", a_result_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_infer_count", a_infer_count, 0);
    check("rst_timeout_err", a_timeout_err, 0);

    // Nominal on dut_a: done 50 cycles after core_start, result 7
    launch();
    check("nom_core_start", a_core_start, 1);
    check("nom_busy_start", a_busy, 1);
    ticks(50);
    check("nom_no_restart", a_core_start, 0);
    check("nom_busy_wait", a_busy, 1);
    bnn_clear = 1'b1;  // ignored in WAIT
    core_done = 1'b1;
    core_result = 4'd7;
    tick();
    bnn_clear = 1'b0;
    core_done = 1'b0;
    check("nom_result_out", a_result_out, 7);
    check("nom_result_ready", a_result_ready, 1);
    check("nom_consume", a_img_consume, 1);
    check("nom_count", a_infer_count, 1);
    check("nom_busy_done", a_busy, 0);
    tick();
    check("nom_consume_once", a_img_consume, 0);
    check("nom_ready_held", a_result_ready, 1);
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    check("nom_clear_ready", a_result_ready, 0);
    check("nom_result_kept", a_result_out, 7);
    tick();
    check("nom_idle_no_start", a_core_start, 0);

    // Retry on dut_b: second core_start exactly 17 cycles after the first
    do_reset();
    launch();
    check("rty_start1", b_core_start, 1);
    first_gap = -1;
    for (int i = 1; i <= 40 && first_gap < 0; i++) begin
      tick();
      if (b_core_start) first_gap = i;
    end
    check("rty_gap", first_gap, 17);
    ticks(5);
    core_done = 1'b1;
    core_result = 4'd3;
    tick();
    core_done = 1'b0;
    check("rty_result", b_result_out, 3);
    check("rty_ready", b_result_ready, 1);
    check("rty_no_err", b_timeout_err, 0);

    // Error on dut_b: two launches, then timeout_err held for 100 cycles
    do_reset();
    launch();
    starts = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_core_start) starts++;
    end
    check("err_starts", starts, 2);
    check("err_flag", b_timeout_err, 1);
    check("err_busy", b_busy, 0);
    err_drops = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!b_timeout_err || b_core_start) err_drops++;
    end
    check("err_held", err_drops, 0);
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    check("err_clear_flag", b_timeout_err, 0);
    check("err_clear_consume", b_img_consume, 1);
    check("err_clear_busy", b_busy, 0);
    tick();
    check("err_consume_once", b_img_consume, 0);

    // Done coincident with the timeout cycle, with saturation of result 12
    do_reset();
    launch();
    ticks(16);
    core_done = 1'b1;
    core_result = 4'd12;
    tick();
    core_done = 1'b0;
    check("coin_ready", b_result_ready, 1);
    check("coin_saturate", b_result_out, 9);
    check("coin_no_retry", b_core_start, 0);
    check("coin_count", b_infer_count, 1);

    // Counter wrap after 256 inferences
    do_reset();
    for (int i = 0; i < 255; i++) quick_infer(4'd1);
    check("wrap_255_a", a_infer_count, 255);
    check("wrap_255_b", b_infer_count, 255);
    quick_infer(4'd2);
    check("wrap_0_a", a_infer_count, 0);
    check("wrap_0_b", b_infer_count, 0);
    check("wrap_result", b_result_out, 2);

    // Reset at WAIT cycle 10, then a stray done
    do_reset();
    quick_infer(4'd5);
    launch();
    ticks(11);
    check("rmw_busy_before", b_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmw_result_out", b_result_out, 0);
    check("rmw_count", b_infer_count, 0);
    check("rmw_busy", b_busy, 0);
    check("rmw_ready", b_result_ready, 0);
    bad_evt = 0;
    core_done = 1'b1;
    core_result = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b_result_ready || b_img_consume || a_result_ready || a_img_consume) bad_evt++;
    end
    core_done = 1'b0;
    check("rmw_late_done", bad_evt, 0);

    // Clear and new request together in DONE
    do_reset();
    launch();
    tick();
    core_done = 1'b1;
    core_result = 4'd6;
    tick();
    core_done = 1'b0;
    check("ovl_ready", b_result_ready, 1);
    bnn_clear = 1'b1;
    bnn_enable = 1'b1;
    img_buffer_full = 1'b1;
    tick();
    bnn_clear = 1'b0;
    check("ovl_idle_ready", b_result_ready, 0);
    check("ovl_no_start", b_core_start, 0);
    check("ovl_idle_busy", b_busy, 0);
    tick();
    bnn_enable = 1'b0;
    img_buffer_full = 1'b0;
    check("ovl_start", b_core_start, 1);
    check("ovl_result_kept", b_result_out, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_scheduler.md
BNN_SCHEDULER -- requirements
Module: bnn_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: max cycles to wait for core_done per attempt (range 2..65535).
REQ-002 The block SHALL have parameter MAX_RETRIES, default 1: number of core restarts after a timeout before reporting an error (range 0..3).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port img_buffer_full, input, 1 bit: the image buffer holds a complete 30x30 frame.
REQ-006 The block SHALL have port bnn_enable, input, 1 bit: host arm, level-sensitive.
REQ-007 The block SHALL have port bnn_clear, input, 1 bit: host acknowledge of a result or error.
REQ-008 The block SHALL have port core_start, output, 1 bit: one-cycle launch pulse to the BNN core data_in_ready.
REQ-009 The block SHALL have port core_done, input, 1 bit: BNN core data_out_ready.
REQ-010 The block SHALL have port core_result, input, 4 bits: BNN core class output.
REQ-011 The block SHALL have port img_consume, output, 1 bit: one-cycle pulse that releases the image buffer.
REQ-012 The block SHALL have port result_out, output, 4 bits: latched class, 0..9.
REQ-013 The block SHALL have port result_ready, output, 1 bit: result_out is valid.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: inference aborted after retries.
REQ-015 The block SHALL have port busy, output, 1 bit: high in START or WAIT.
REQ-016 The block SHALL have port infer_count, output, 8 bits: count of completed inferences.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT, DONE and ERROR, and all outputs SHALL be registered.
REQ-018 In IDLE, an edge sampling bnn_enable=1 and img_buffer_full=1 SHALL move the FSM to START; otherwise it stays in IDLE.
REQ-019 In START, core_start SHALL be 1 for exactly that one cycle; the timer SHALL clear to 0; the next state SHALL be WAIT.
REQ-020 In WAIT, the 16-bit timer SHALL increment by 1 per cycle.
REQ-021 In WAIT, core_done=1 SHALL have these effects on the same edge: result_out loads core_result, or 4'd9 if core_result>9 (saturate); result_ready goes to 1; img_consume pulses for 1 cycle; infer_count increments, wrapping 255->0; retry count clears; the next state is DONE.
REQ-022 In WAIT, with core_done=0 and timer==TIMEOUT_CYCLES-1: if retry count<MAX_RETRIES, the retry count SHALL increment and the FSM SHALL go to START; otherwise the FSM SHALL go to ERROR with timeout_err set to 1.
REQ-023 If core_done and the timeout occur in the same cycle, done SHALL win.
REQ-024 core_done outside WAIT SHALL be ignored, including a late done arriving after a retry launch.
REQ-025 Result latency SHALL be: result_ready high on the first edge after core_done is sampled in WAIT.
REQ-026 Launch latency SHALL be: core_start high in the cycle after the IDLE request is sampled.
REQ-027 DONE SHALL hold result_ready=1 and result_out stable until bnn_clear=1 is sampled; then result_ready goes to 0 and the FSM goes to IDLE.
REQ-028 result_out SHALL retain its value after clear, until the next completed inference.
REQ-029 ERROR SHALL hold timeout_err=1 until bnn_clear=1; then timeout_err goes to 0, img_consume pulses once, the retry count clears, and the FSM goes to IDLE.
REQ-030 bnn_clear SHALL be ignored in IDLE, START and WAIT.
REQ-031 Deasserting bnn_enable or img_buffer_full during START or WAIT SHALL NOT abort the inference in progress.
REQ-032 The block SHALL start at most one inference per bnn_clear: after clear, a new launch needs bnn_enable=1 and img_buffer_full=1 sampled again in IDLE.
REQ-033 If bnn_clear and a new request are both high in the same DONE cycle, the FSM SHALL go only to IDLE, with launch no earlier than the following edge.

Reset
REQ-034 When rst_n=0 is sampled on a clk edge, the block SHALL set: state IDLE, core_start 0, img_consume 0, result_out 0, result_ready 0, timeout_err 0, busy 0, infer_count 0, timer 0, retry count 0.
REQ-035 Reset asserted mid-WAIT SHALL abort the inference, with no img_consume pulse and no count change.
REQ-036 After reset deasserts, a subsequent core_done SHALL be ignored until a new launch.

Verification
REQ-037 The bench SHALL cover nominal: enable=1, full=1; core_done at 50 cycles after core_start with core_result=7 -> result_out=7, result_ready=1 one cycle later, one img_consume pulse, infer_count=1; clear -> IDLE.
REQ-038 The bench SHALL cover retry: TIMEOUT_CYCLES=16, MAX_RETRIES=1; no done on the first attempt -> second core_start exactly 17 cycles after the first; done with result 3 -> result_out=3, timeout_err=0.
REQ-039 The bench SHALL cover error: TIMEOUT_CYCLES=16, MAX_RETRIES=1; done never arrives -> two core_start pulses, then timeout_err=1 held for 100 cycles; clear -> timeout_err=0, one img_consume pulse, busy=0.
REQ-040 The bench SHALL cover boundaries: core_done coincident with the timeout cycle -> DONE, no retry; core_result=12 -> result_out=9; 256 inferences -> infer_count=0.
REQ-041 The bench SHALL cover reset mid-WAIT: rst_n=0 for 1 cycle at WAIT cycle 10 -> all outputs at reset values; a later core_done -> no result_ready and no img_consume.
REQ-042 The bench SHALL cover clear/request overlap: bnn_clear and request high together in DONE -> IDLE next edge, core_start one cycle later.
